// File: rtl/fetch_stage_if.sv
// Bundle of the fetch stage's memory, hazard-control and F/D latch signals.
// Optional FETCH_PERF_EN adds the fetch/stall performance counter outputs.
interface fetch_stage_if;
  // Instruction memory response and hazard-unit controls.
  logic        ihit;
  logic [31:0] imemload;
  logic        PC_WEN;
  logic [1:0]  PCSrc_check;
  logic [31:0] branch_target;
  logic [25:0] jump_addr;
  logic [31:0] jr_target;
  logic [1:0]  fd_state;
  logic        halt;

  // Fetch request and F/D latch contents.
  logic        imemREN;
  logic [31:0] imemaddr;
  logic [31:0] fd_instr;
  logic [31:0] fd_pcplus4;
  logic        fd_valid;
  logic        halted;

`ifdef FETCH_PERF_EN
  logic [31:0] fetch_count;
  logic [31:0] stall_count;

  modport master (
    input  ihit, imemload, PC_WEN, PCSrc_check, branch_target, jump_addr,
           jr_target, fd_state, halt,
    output imemREN, imemaddr, fd_instr, fd_pcplus4, fd_valid, halted,
           fetch_count, stall_count
  );

  modport slave (
    output ihit, imemload, PC_WEN, PCSrc_check, branch_target, jump_addr,
           jr_target, fd_state, halt,
    input  imemREN, imemaddr, fd_instr, fd_pcplus4, fd_valid, halted,
           fetch_count, stall_count
  );
`else
  modport master (
    input  ihit, imemload, PC_WEN, PCSrc_check, branch_target, jump_addr,
           jr_target, fd_state, halt,
    output imemREN, imemaddr, fd_instr, fd_pcplus4, fd_valid, halted
  );

  modport slave (
    output ihit, imemload, PC_WEN, PCSrc_check, branch_target, jump_addr,
           jr_target, fd_state, halt,
    input  imemREN, imemaddr, fd_instr, fd_pcplus4, fd_valid, halted
  );
`endif
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, redirect hold-over and the F/D latch.
// Optional macro FETCH_PERF_EN adds fetch_count / stall_count counters.
module fetch_stage #(
  parameter logic [31:0] PC_INIT  = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input logic           CLK,
  input logic           RST,
  fetch_stage_if.master bus
);

  typedef enum logic [1:0] {
    ST_BOOT   = 2'b00,
    ST_FETCH  = 2'b01,
    ST_HALTED = 2'b10
  } state_t;

  typedef enum logic [1:0] {
    PS_ENABLE   = 2'b00,
    PS_STALL    = 2'b01,
    PS_FLUSH    = 2'b10,
    PS_RESERVED = 2'b11
  } pipe_state_t;

  typedef enum logic [1:0] {
    SRC_SEQ    = 2'b00,
    SRC_BRANCH = 2'b01,
    SRC_JUMP   = 2'b10,
    SRC_JR     = 2'b11
  } pc_src_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        pend_valid_q, pend_valid_d;
  logic [31:0] pend_target_q, pend_target_d;
  logic [31:0] fd_instr_q, fd_instr_d;
  logic [31:0] fd_pcplus4_q, fd_pcplus4_d;
  logic        fd_valid_q, fd_valid_d;
  logic        halted_q, halted_d;

  logic [31:0] pc_plus4;
  logic [31:0] live_target;
  logic        fetching;
  logic        redirect_req;
  pipe_state_t fd_ctl;
  pc_src_t     pc_src;

  assign pc_src       = pc_src_t'(bus.PCSrc_check);
  assign fd_ctl       = pipe_state_t'(bus.fd_state);
  assign pc_plus4     = pc_q + 32'd4;
  assign fetching     = (state_q == ST_FETCH);
  assign redirect_req = (pc_src != SRC_SEQ);

  // Jump keeps the region bits of the instruction currently in decode.
  always_comb begin
    live_target = pc_plus4;
    case (pc_src)
      SRC_BRANCH: live_target = bus.branch_target;
      SRC_JUMP:   live_target = {fd_pcplus4_q[31:28], bus.jump_addr, 2'b00};
      SRC_JR:     live_target = bus.jr_target;
      default:    live_target = pc_plus4;
    endcase
  end

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    state_d = state_q;
    case (state_q)
      ST_BOOT:   state_d = bus.halt ? ST_HALTED : ST_FETCH;
      ST_FETCH:  state_d = bus.halt ? ST_HALTED : ST_FETCH;
      ST_HALTED: state_d = ST_HALTED;
      default:   state_d = ST_BOOT;
    endcase
  end

  // Redirects that arrive while the PC is frozen are parked until PC_WEN.
  always_comb begin
    pc_d          = pc_q;
    pend_valid_d  = pend_valid_q;
    pend_target_d = pend_target_q;
    if (fetching && !bus.halt) begin
      if (bus.PC_WEN) begin
        if (redirect_req) begin
          pc_d = live_target;
        end else if (pend_valid_q) begin
          pc_d = pend_target_q;
        end else begin
          pc_d = pc_plus4;
        end
        pend_valid_d = 1'b0;
      end else if (redirect_req) begin
        pend_target_d = live_target;
        pend_valid_d  = 1'b1;
      end
    end
  end

  always_comb begin
    fd_instr_d   = fd_instr_q;
    fd_pcplus4_d = fd_pcplus4_q;
    fd_valid_d   = fd_valid_q;
    halted_d     = halted_q;
    if (state_q != ST_HALTED && bus.halt) begin
      fd_instr_d   = NOP_WORD;
      fd_pcplus4_d = 32'd0;
      fd_valid_d   = 1'b0;
      halted_d     = 1'b1;
    end else if (fetching) begin
      case (fd_ctl)
        PS_ENABLE: begin
          if (bus.ihit) begin
            fd_instr_d   = bus.imemload;
            fd_pcplus4_d = pc_plus4;
            fd_valid_d   = 1'b1;
          end else begin
            fd_instr_d = NOP_WORD;
            fd_valid_d = 1'b0;
          end
        end
        PS_FLUSH: begin
          fd_instr_d   = NOP_WORD;
          fd_pcplus4_d = 32'd0;
          fd_valid_d   = 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values of the others.
    if (RST) begin
      state_q       <= ST_BOOT;
      pc_q          <= PC_INIT;
      pend_valid_q  <= 1'b0;
      pend_target_q <= 32'd0;
      fd_instr_q    <= NOP_WORD;
      fd_pcplus4_q  <= 32'd0;
      fd_valid_q    <= 1'b0;
      halted_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      pend_valid_q  <= pend_valid_d;
      pend_target_q <= pend_target_d;
      fd_instr_q    <= fd_instr_d;
      fd_pcplus4_q  <= fd_pcplus4_d;
      fd_valid_q    <= fd_valid_d;
      halted_q      <= halted_d;
    end
  end

  assign bus.imemREN    = fetching;
  assign bus.imemaddr   = pc_q;
  assign bus.fd_instr   = fd_instr_q;
  assign bus.fd_pcplus4 = fd_pcplus4_q;
  assign bus.fd_valid   = fd_valid_q;
  assign bus.halted     = halted_q;

`ifdef FETCH_PERF_EN
  logic [31:0] fetch_count_q, fetch_count_d;
  logic [31:0] stall_count_q, stall_count_d;

  // Counters only move in FETCH, so they freeze once HALTED is reached.
  always_comb begin
    fetch_count_d = fetch_count_q;
    stall_count_d = stall_count_q;
    if (fetching && bus.ihit && fd_ctl == PS_ENABLE) begin
      fetch_count_d = fetch_count_q + 32'd1;
    end
    if (fetching && !bus.PC_WEN) begin
      stall_count_d = stall_count_q + 32'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      fetch_count_q <= 32'd0;
      stall_count_q <= 32'd0;
    end else begin
      fetch_count_q <= fetch_count_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign bus.fetch_count = fetch_count_q;
  assign bus.stall_count = stall_count_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed, table-driven bench for fetch_stage; covers reset, redirects, flush,
// halt and PC wrap, plus the perf counters when FETCH_PERF_EN is defined.
module tb_fetch_stage;

  logic clk;
  logic rst;

  fetch_stage_if bus ();

  fetch_stage #(
    .PC_INIT (32'h0000_0000),
    .NOP_WORD(32'h0000_0000)
  ) dut (
    .CLK(clk),
    .RST(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [1:0] ENA = 2'b00;
  localparam logic [1:0] STL = 2'b01;
  localparam logic [1:0] FLS = 2'b10;
  localparam logic [1:0] RSV = 2'b11;

  typedef struct {
    logic        rst;
    logic        ihit;
    logic [31:0] load;
    logic        wen;
    logic [1:0]  src;
    logic [31:0] br;
    logic [25:0] ja;
    logic [31:0] jr;
    logic [1:0]  fds;
    logic        halt;
    logic        e_ren;
    logic [31:0] e_addr;
    logic [31:0] e_instr;
    logic [31:0] e_p4;
    logic        e_valid;
    logic        e_halted;
  } vec_t;

  int total = 0;
  int bad   = 0;
  vec_t vq[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t v(
    input logic r, input logic ih, input logic [31:0] ld, input logic we,
    input logic [1:0] sr, input logic [31:0] b, input logic [25:0] j,
    input logic [31:0] jrt, input logic [1:0] fs, input logic h,
    input logic ren, input logic [31:0] addr, input logic [31:0] ins,
    input logic [31:0] p4, input logic vld, input logic hlt);
    vec_t t;
    t.rst = r;  t.ihit = ih; t.load = ld; t.wen = we; t.src = sr;
    t.br = b;   t.ja = j;    t.jr = jrt;  t.fds = fs; t.halt = h;
    t.e_ren = ren; t.e_addr = addr; t.e_instr = ins; t.e_p4 = p4;
    t.e_valid = vld; t.e_halted = hlt;
    return t;
  endfunction

  // Drive away from the edge, clock once, then sample 1 time unit after it.
  task automatic run_vec(input vec_t t, input string tag);
    @(negedge clk);
    rst               = t.rst;
    bus.ihit          = t.ihit;
    bus.imemload      = t.load;
    bus.PC_WEN        = t.wen;
    bus.PCSrc_check   = t.src;
    bus.branch_target = t.br;
    bus.jump_addr     = t.ja;
    bus.jr_target     = t.jr;
    bus.fd_state      = t.fds;
    bus.halt          = t.halt;
    @(posedge clk);
    #1;
    check({tag, ".imemREN"},    {31'd0, bus.imemREN},  {31'd0, t.e_ren});
    check({tag, ".imemaddr"},   bus.imemaddr,          t.e_addr);
    check({tag, ".fd_instr"},   bus.fd_instr,          t.e_instr);
    check({tag, ".fd_pcplus4"}, bus.fd_pcplus4,        t.e_p4);
    check({tag, ".fd_valid"},   {31'd0, bus.fd_valid}, {31'd0, t.e_valid});
    check({tag, ".halted"},     {31'd0, bus.halted},   {31'd0, t.e_halted});
  endtask

  initial begin
    rst = 1'b1;
    bus.ihit = 1'b0; bus.imemload = '0; bus.PC_WEN = 1'b0; bus.PCSrc_check = '0;
    bus.branch_target = '0; bus.jump_addr = '0; bus.jr_target = '0;
    bus.fd_state = ENA; bus.halt = 1'b0;

    //         rst ih load           we src br             ja       jr             fds  h | ren addr           instr          p4             v  hl
    // Reset, BOOT, then sequential fetch 0,4,8,C.
    vq.push_back(v(1, 0, 32'h0,          0, 0, 32'h0,         26'h0,  32'h0,         ENA, 0, 0, 32'h0,         32'h0,         32'h0,         0, 0));
    vq.push_back(v(1, 0, 32'h0,          0, 0, 32'h0,         26'h0,  32'h0,         ENA, 0, 0, 32'h0,         32'h0,         32'h0,         0, 0));
    vq.push_back(v(0, 1, 32'hAAAA0000,   1, 0, 32'h0,         26'h0,  32'h0,         ENA, 0, 1, 32'h0,         32'h0,         32'h0,         0, 0));
    vq.push_back(v(0, 1, 32'h11110000,   1, 0, 32'h0,         26'h0,  32'h0,         ENA, 0, 1, 32'h4,         32'h11110000,  32'h4,         1, 0));
    vq.push_back(v(0, 1, 32'h22220000,   1, 0, 32'h0,         26'h0,  32'h0,         ENA, 0, 1, 32'h8,         32'h22220000,  32'h8,         1, 0));
    vq.push_back(v(0, 1, 32'h33330000,   1, 0, 32'h0,         26'h0,  32'h0,         ENA, 0, 1, 32'hC,         32'h33330000,  32'hC,         1, 0));
    // jr to 0x40, then branch to 0x100 held over 3 frozen cycles (0x200 overwritten).
    vq.push_back(v(0, 0, 32'h0,          1, 3, 32'h0,         26'h0,  32'h40,        STL, 0, 1, 32'h40,        32'h33330000,  32'hC,         1, 0));
    vq.push_back(v(0, 0, 32'h0,          0, 1, 32'h200,       26'h0,  32'h0,         STL, 0, 1, 32'h40,        32'h33330000,  32'hC,         1, 0));
    vq.push_back(v(0, 0, 32'h0,          0, 1, 32'h100,       26'h0,  32'h0,         STL, 0, 1, 32'h40,        32'h33330000,  32'hC,         1, 0));
    vq.push_back(v(0, 0, 32'h0,          0, 1, 32'h100,       26'h0,  32'h0,         STL, 0, 1, 32'h40,        32'h33330000,  32'hC,         1, 0));
    vq.push_back(v(0, 0, 32'h0,          1, 0, 32'h0,         26'h0,  32'h0,         STL, 0, 1, 32'h100,       32'h33330000,  32'hC,         1, 0));
    vq.push_back(v(0, 1, 32'h44440000,   1, 0, 32'h0,         26'h0,  32'h0,         ENA, 0, 1, 32'h104,       32'h44440000,  32'h104,       1, 0));
    // Parked branch to 0x300 loses to a live jr to 0x500; pending is dropped.
    vq.push_back(v(0, 0, 32'h0,          0, 1, 32'h300,       26'h0,  32'h0,         STL, 0, 1, 32'h104,       32'h44440000,  32'h104,       1, 0));
    vq.push_back(v(0, 0, 32'h0,          1, 3, 32'h0,         26'h0,  32'h500,       STL, 0, 1, 32'h500,       32'h44440000,  32'h104,       1, 0));
    vq.push_back(v(0, 0, 32'h0,          1, 0, 32'h0,         26'h0,  32'h0,         STL, 0, 1, 32'h504,       32'h44440000,  32'h104,       1, 0));
    // Jump using fd_pcplus4 = 0x1000_0008.
    vq.push_back(v(0, 0, 32'h0,          1, 3, 32'h0,         26'h0,  32'h10000004,  STL, 0, 1, 32'h10000004,  32'h44440000,  32'h104,       1, 0));
    vq.push_back(v(0, 1, 32'h55550000,   0, 0, 32'h0,         26'h0,  32'h0,         ENA, 0, 1, 32'h10000004,  32'h55550000,  32'h10000008,  1, 0));
    vq.push_back(v(0, 0, 32'h0,          1, 2, 32'h0,         26'h40, 32'h0,         STL, 0, 1, 32'h10000100,  32'h55550000,  32'h10000008,  1, 0));
    // Flush beats ihit, then stall holds the flushed latch.
    vq.push_back(v(0, 1, 32'h21080001,   0, 0, 32'h0,         26'h0,  32'h0,         FLS, 0, 1, 32'h10000100,  32'h0,         32'h0,         0, 0));
    vq.push_back(v(0, 1, 32'h12345678,   0, 0, 32'h0,         26'h0,  32'h0,         STL, 0, 1, 32'h10000100,  32'h0,         32'h0,         0, 0));
    // ENABLE with and without ihit.
    vq.push_back(v(0, 1, 32'h66660000,   0, 0, 32'h0,         26'h0,  32'h0,         ENA, 0, 1, 32'h10000100,  32'h66660000,  32'h10000104,  1, 0));
    vq.push_back(v(0, 0, 32'h0,          0, 0, 32'h0,         26'h0,  32'h0,         ENA, 0, 1, 32'h10000100,  32'h0,         32'h10000104,  0, 0));
    // Halt at 0x20; PC and latch frozen while PC_WEN and controls toggle.
    vq.push_back(v(0, 0, 32'h0,          1, 3, 32'h0,         26'h0,  32'h20,        STL, 0, 1, 32'h20,        32'h0,         32'h10000104,  0, 0));
    vq.push_back(v(0, 1, 32'h77770000,   1, 0, 32'h0,         26'h0,  32'h0,         ENA, 1, 0, 32'h20,        32'h0,         32'h0,         0, 1));
    vq.push_back(v(0, 1, 32'h99990000,   0, 1, 32'h400,       26'h0,  32'h0,         ENA, 0, 0, 32'h20,        32'h0,         32'h0,         0, 1));
    vq.push_back(v(0, 1, 32'h99990000,   1, 0, 32'h0,         26'h0,  32'h0,         ENA, 0, 0, 32'h20,        32'h0,         32'h0,         0, 1));
    vq.push_back(v(0, 1, 32'h99990000,   0, 3, 32'h0,         26'h0,  32'h800,       ENA, 0, 0, 32'h20,        32'h0,         32'h0,         0, 1));
    vq.push_back(v(0, 1, 32'h99990000,   1, 0, 32'h0,         26'h0,  32'h0,         ENA, 1, 0, 32'h20,        32'h0,         32'h0,         0, 1));
    vq.push_back(v(0, 1, 32'h99990000,   0, 0, 32'h0,         26'h0,  32'h0,         ENA, 0, 0, 32'h20,        32'h0,         32'h0,         0, 1));
    vq.push_back(v(1, 0, 32'h0,          0, 0, 32'h0,         26'h0,  32'h0,         ENA, 0, 0, 32'h0,         32'h0,         32'h0,         0, 0));
    // PC wrap from 0xFFFF_FFFC to 0; fd_pcplus4 wraps too.
    vq.push_back(v(0, 0, 32'h0,          1, 0, 32'h0,         26'h0,  32'h0,         STL, 0, 1, 32'h0,         32'h0,         32'h0,         0, 0));
    vq.push_back(v(0, 0, 32'h0,          1, 3, 32'h0,         26'h0,  32'hFFFFFFFC,  STL, 0, 1, 32'hFFFFFFFC,  32'h0,         32'h0,         0, 0));
    vq.push_back(v(0, 1, 32'h88880000,   1, 0, 32'h0,         26'h0,  32'h0,         ENA, 0, 1, 32'h0,         32'h88880000,  32'h0,         1, 0));
    // Reset clears a parked redirect.
    vq.push_back(v(0, 0, 32'h0,          0, 1, 32'h900,       26'h0,  32'h0,         STL, 0, 1, 32'h0,         32'h88880000,  32'h0,         1, 0));
    vq.push_back(v(1, 0, 32'h0,          0, 0, 32'h0,         26'h0,  32'h0,         STL, 0, 0, 32'h0,         32'h0,         32'h0,         0, 0));
    vq.push_back(v(0, 0, 32'h0,          1, 0, 32'h0,         26'h0,  32'h0,         STL, 0, 1, 32'h0,         32'h0,         32'h0,         0, 0));
    vq.push_back(v(0, 0, 32'h0,          1, 0, 32'h0,         26'h0,  32'h0,         STL, 0, 1, 32'h4,         32'h0,         32'h0,         0, 0));
    // Reserved fd_state behaves as STALL.
    vq.push_back(v(0, 1, 32'hCAFE0000,   0, 0, 32'h0,         26'h0,  32'h0,         ENA, 0, 1, 32'h4,         32'hCAFE0000,  32'h8,         1, 0));
    vq.push_back(v(0, 1, 32'hDEAD0000,   1, 0, 32'h0,         26'h0,  32'h0,         RSV, 0, 1, 32'h8,         32'hCAFE0000,  32'h8,         1, 0));

    foreach (vq[i]) run_vec(vq[i], $sformatf("v%0d", i));

    // Halt raised during the BOOT cycle goes straight to HALTED.
    run_vec(v(1, 0, 32'h0, 0, 0, 32'h0, 26'h0, 32'h0, ENA, 0, 0, 32'h0, 32'h0, 32'h0, 0, 0), "boot_rst");
    run_vec(v(0, 1, 32'h1, 1, 0, 32'h0, 26'h0, 32'h0, ENA, 1, 0, 32'h0, 32'h0, 32'h0, 0, 1), "boot_halt");
    run_vec(v(0, 1, 32'h2, 1, 0, 32'h0, 26'h0, 32'h0, ENA, 0, 0, 32'h0, 32'h0, 32'h0, 0, 1), "boot_halt_hold");

`ifdef FETCH_PERF_EN
    begin
      run_vec(v(1, 0, 32'h0, 0, 0, 32'h0, 26'h0, 32'h0, ENA, 0, 0, 32'h0, 32'h0, 32'h0, 0, 0), "perf_rst");
      check("perf.fetch_reset", bus.fetch_count, 32'd0);
      check("perf.stall_reset", bus.stall_count, 32'd0);
      // BOOT cycle: no counting.
      run_vec(v(0, 0, 32'h0, 0, 0, 32'h0, 26'h0, 32'h0, STL, 0, 1, 32'h0, 32'h0, 32'h0, 0, 0), "perf_boot");
      check("perf.fetch_boot", bus.fetch_count, 32'd0);
      check("perf.stall_boot", bus.stall_count, 32'd0);
      for (int k = 0; k < 10; k++) begin
        logic [31:0] a;
        a = 32'(4 * (k + 1));
        run_vec(v(0, 1, 32'h100 + 32'(k), 1, 0, 32'h0, 26'h0, 32'h0, ENA, 0,
                  1, a, 32'h100 + 32'(k), a, 1, 0), $sformatf("perf_f%0d", k));
      end
      for (int k = 0; k < 3; k++) begin
        run_vec(v(0, 0, 32'h0, 0, 0, 32'h0, 26'h0, 32'h0, STL, 0,
                  1, 32'd40, 32'h109, 32'd40, 1, 0), $sformatf("perf_s%0d", k));
      end
      check("perf.fetch_count", bus.fetch_count, 32'd10);
      check("perf.stall_count", bus.stall_count, 32'd3);
      run_vec(v(0, 0, 32'h0, 1, 0, 32'h0, 26'h0, 32'h0, STL, 1, 0, 32'd40, 32'h0, 32'h0, 0, 1), "perf_halt");
      for (int k = 0; k < 3; k++) begin
        run_vec(v(0, 1, 32'h5, 0, 0, 32'h0, 26'h0, 32'h0, ENA, 0,
                  0, 32'd40, 32'h0, 32'h0, 0, 1), $sformatf("perf_h%0d", k));
      end
      check("perf.fetch_frozen", bus.fetch_count, 32'd10);
      check("perf.stall_frozen", bus.stall_count, 32'd3);
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
